fetch_stage: RTL and testbench
==============================

# fetch_stage

Front end of the SRV1 pipeline and producer of the fetch→decode interface: it owns the program counter and issues word-address requests on the instruction memory port. It registers each returned instruction together with its 30-bit word PC for the decode stage, and inserts canonical NOPs when no instruction is available. It also applies redirects from the execute stage, squashing wrong-path requests that are still in flight.

## Interface
Parameters:
- RESET_PC, 30'h0000_0000, word address of the first fetch after reset

Ports:
- clk  input  1  clock; all state updates on rising edge
- sync_rst  input  1  synchronous reset, active-high
- clk_en  input  1  pipeline advance; gates only the fetch→decode output registers
- redirect  input  1  execute-stage redirect (same cycle as decode's invalidate)
- redirect_pc  input  30  word address to resume fetching from
- imem_req  output  1  request valid
- imem_addr  output  30  request word address
- imem_ack  input  1  request accepted; imem_rdata valid this cycle
- imem_rdata  input  32  instruction word
- inst_out  output  32  instruction to decode
- pc_out  output  30  word PC of inst_out

## Operation
- NOP = 32'h0000_0013 (addi x0,x0,0). Every bubble presents this value.
- Registers:
  - next_pc: next address to fetch.
  - addr: address currently on the bus; drives imem_addr.
  - hold_inst / hold_pc: one-entry skid buffer.
  - out registers: inst_out, pc_out.
- Bus rule: once imem_req is high, imem_addr stays stable until the imem_ack cycle. A request is never withdrawn. At most one request is outstanding.
- States:
  - FETCH: imem_req=1.
  - HELD: imem_req=0; the buffer is full.
  - DRAIN: imem_req=1; the returning data is discarded.
- FETCH, no redirect:
  - ack & clk_en: inst_out←rdata, pc_out←addr, addr←next_pc←addr+1. Stay in FETCH, so a back-to-back request goes out next cycle.
  - ack & !clk_en: hold←{rdata,addr}, next_pc←addr+1 → HELD.
  - !ack & clk_en: inst_out←NOP; pc_out holds its value.
- HELD, no redirect:
  - clk_en: inst_out←hold_inst, pc_out←hold_pc, addr←next_pc → FETCH.
  - !clk_en: everything holds.
- DRAIN:
  - ack: discard rdata, addr←next_pc → FETCH.
  - While in DRAIN with clk_en high, inst_out←NOP.
- Redirect has priority over every rule above and is honoured regardless of clk_en.
  - Always: inst_out←NOP, and next_pc←redirect_pc.
  - FETCH with ack: the data is discarded, addr←redirect_pc, stay in FETCH.
  - FETCH without ack: → DRAIN, addr held.
  - HELD: the buffer is dropped, addr←redirect_pc → FETCH.
  - DRAIN without ack: stay in DRAIN; the latest redirect_pc wins.
  - DRAIN with ack: addr←redirect_pc → FETCH.
- PC arithmetic is modulo 2^30: 30'h3FFF_FFFF+1 wraps to 30'h0.

## Timing
- Reset (sync_rst high at an edge): state←FETCH, addr←next_pc←RESET_PC, inst_out←NOP, pc_out←RESET_PC, buffer empty.
  - imem_req is forced to 0 in every cycle where sync_rst is high; imem_addr=RESET_PC.
  - Reset mid-request abandons the request. The memory must also be reset.
- First request is issued in the first cycle after reset deasserts.
- Latency: a request acked in cycle N (with clk_en=1) appears on inst_out after the edge ending cycle N.
- With a zero-wait memory (ack in the same cycle as req), throughput is one instruction per cycle.
- A redirect in cycle N:
  - NOP appears on inst_out after edge N.
  - Earliest request to redirect_pc is cycle N+1 (from FETCH with ack, or HELD). From DRAIN it comes in the cycle after the pending ack.
- With clk_en low, inst_out/pc_out hold; only a redirect overrides this, forcing NOP.

## Test plan
- Reset, zero-wait memory returning word=addr: RESET_PC=30'h10. Expect imem_addr 0x10, 0x11, 0x12… on consecutive cycles; pc_out 0x10, 0x11…; inst_out matches one cycle later.
- 2-wait-state memory: each instruction is followed by two NOP bubbles. imem_addr is stable across the wait cycles; pc_out is held during bubbles.
- clk_en low for 3 cycles coinciding with an ack at addr 0x20: the buffer fills and imem_req drops. On clk_en rising, inst_out=mem[0x20] and pc_out=0x20, then the next request is 0x21. No instruction is lost or duplicated.
- Redirect to 0x100 while a 3-wait request to 0x40 is pending: imem_addr stays 0x40 until ack and that data never reaches inst_out. The next request is 0x100; inst_out is NOP from the redirect until mem[0x100].
- Two redirects (0x200, then 0x300) during one drain, plus a redirect while HELD with clk_en low: only 0x300 is fetched, the buffer is discarded, and inst_out=NOP immediately.
- PC wrap: redirect to 30'h3FFF_FFFF. Next addresses are 0x3FFF_FFFF then 0x0. Asserting sync_rst mid-stream gives NOP/RESET_PC outputs and imem_req=0 during reset.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: front end of the SRV1 pipeline.
// Owns the program counter and issues word-address requests to instruction
// memory. Each returned instruction is registered with its 30-bit word PC for
// decode. Canonical NOPs fill every bubble. Redirects from execute override
// everything, and a request already on the bus is squashed rather than
// withdrawn.
//
// Ports:
//   clk          clock, rising edge
//   sync_rst     synchronous reset, active-high
//   clk_en       pipeline advance; gates only the inst_out/pc_out registers
//   redirect     execute-stage redirect
//   redirect_pc  word address to resume fetching from
//   imem_req     request valid
//   imem_addr    request word address
//   imem_ack     request accepted; imem_rdata valid this cycle
//   imem_rdata   instruction word
//   inst_out     instruction to decode
//   pc_out       word PC of inst_out
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_FETCH | request for addr on the bus
// ST_HELD  | skid buffer full, waiting for clk_en; no request
// ST_DRAIN | wrong-path request on the bus; its data will be dropped
module fetch_stage #(
  parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic        clk_en,
  input  logic        redirect,
  input  logic [29:0] redirect_pc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [29:0] pc_out
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HELD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state;
  logic [29:0] next_pc;
  logic [29:0] addr;
  logic [31:0] hold_inst;
  logic [29:0] hold_pc;
  logic [31:0] inst_q;
  logic [29:0] pc_q;

  // Request is masked combinationally during reset so an in-flight request
  // is abandoned in the very cycle reset is asserted.
  assign imem_req  = !sync_rst && (state != ST_HELD);
  assign imem_addr = sync_rst ? RESET_PC : addr;
  assign inst_out  = inst_q;
  assign pc_out    = pc_q;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state     <= ST_FETCH;
      next_pc   <= RESET_PC;
      addr      <= RESET_PC;
      hold_inst <= NOP;
      hold_pc   <= RESET_PC;
      inst_q    <= NOP;
      pc_q      <= RESET_PC;
    end else if (redirect) begin
      // Redirect ignores clk_en: the wrong-path instruction must not linger.
      inst_q  <= NOP;
      next_pc <= redirect_pc;
      case (state)
        ST_FETCH: begin
          if (imem_ack) addr  <= redirect_pc;
          else          state <= ST_DRAIN;  // addr must stay stable until ack
        end
        ST_HELD: begin
          addr  <= redirect_pc;
          state <= ST_FETCH;
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            addr  <= redirect_pc;
            state <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            next_pc <= addr + 30'd1;
            if (clk_en) begin
              inst_q <= imem_rdata;
              pc_q   <= addr;
              addr   <= addr + 30'd1;
            end else begin
              hold_inst <= imem_rdata;
              hold_pc   <= addr;
              state     <= ST_HELD;
            end
          end else if (clk_en) begin
            inst_q <= NOP;
          end
        end
        ST_HELD: begin
          if (clk_en) begin
            inst_q <= hold_inst;
            pc_q   <= hold_pc;
            addr   <= next_pc;
            state  <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            addr  <= next_pc;
            state <= ST_FETCH;
          end
          if (clk_en) inst_q <= NOP;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [29:0] RPC = 30'h10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        sync_rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        redirect = 1'b0;
  logic [29:0] redirect_pc = '0;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst_out;
  logic [29:0] pc_out;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_out(inst_out),
    .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents never collide with NOP.
  function automatic logic [31:0] mw(input logic [29:0] a);
    return {2'b10, a};
  endfunction

  // ---------------- reference model ----------------
  // Tracks the fetch stream as: bus address in use, whether the bus data is
  // wrong-path, a queue of fetched-but-undelivered instructions, and where
  // fetching continues after the queue/squash clears.
  typedef struct packed {logic [31:0] inst; logic [29:0] pc;} ent_t;
  ent_t        m_buf[$];
  logic [29:0] m_bus = RPC;
  logic [29:0] m_resume = RPC;
  bit          m_squash = 0;
  logic [31:0] m_inst = NOP;
  logic [29:0] m_pc = RPC;

  task automatic model_step(input bit rst, input bit en, input bit rd,
                            input logic [29:0] rpc, input bit ack,
                            input logic [31:0] rdata);
    ent_t e;
    if (rst) begin
      m_bus = RPC; m_resume = RPC; m_squash = 0; m_buf.delete();
      m_inst = NOP; m_pc = RPC;
    end else if (rd) begin
      m_inst = NOP;
      m_resume = rpc;
      if (m_buf.size() != 0) begin
        m_buf.delete();
        m_bus = rpc;
      end else if (ack) begin
        m_bus = rpc;
        m_squash = 0;
      end else begin
        m_squash = 1;
      end
    end else if (m_buf.size() != 0) begin
      if (en) begin
        e = m_buf.pop_front();
        m_inst = e.inst; m_pc = e.pc;
        m_bus = m_resume;
      end
    end else if (m_squash) begin
      if (ack) begin m_squash = 0; m_bus = m_resume; end
      if (en) m_inst = NOP;
    end else if (ack) begin
      m_resume = m_bus + 30'd1;
      if (en) begin
        m_inst = rdata; m_pc = m_bus;
        m_bus = m_bus + 30'd1;
      end else begin
        e.inst = rdata; e.pc = m_bus;
        m_buf.push_back(e);
      end
    end else if (en) begin
      m_inst = NOP;
    end
  endtask

  // ---------------- memory + cycle driver ----------------
  int mem_waits = 0;
  int mem_cnt = 0;
  bit mem_rand = 0;
  bit saw_40 = 0;
  logic        s_req;
  logic [29:0] s_addr;
  logic [31:0] s_inst;
  logic [29:0] s_pc;

  // force_ack < 0 lets the memory model decide; otherwise it scripts ack.
  task automatic cycle(input bit rst, input bit en, input bit rd,
                       input logic [29:0] rpc, input int force_ack,
                       input bit chk_model);
    bit a;
    sync_rst = rst; clk_en = en; redirect = rd; redirect_pc = rpc;
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    #1;
    s_req = imem_req; s_addr = imem_addr;
    if (chk_model) begin
      chk("imem_req", 32'(s_req), 32'(!rst && m_buf.size() == 0));
      chk("imem_addr", 32'(s_addr), 32'(rst ? RPC : m_bus));
    end
    a = 0;
    if (force_ack >= 0) begin
      a = (force_ack != 0);
      mem_cnt = 0;
    end else if (s_req) begin
      if (mem_rand ? ($urandom_range(2) == 0) : (mem_cnt >= mem_waits)) begin
        a = 1; mem_cnt = 0;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
    imem_ack = a;
    if (a) imem_rdata = mw(s_addr);
    model_step(rst, en, rd, rpc, a, imem_rdata);
    @(posedge clk);
    #1;
    s_inst = inst_out; s_pc = pc_out;
    if (s_inst == mw(30'h40)) saw_40 = 1;
    if (chk_model) begin
      chk("inst_out", s_inst, m_inst);
      chk("pc_out", 32'(s_pc), 32'(m_pc));
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit rst; bit en; bit rd; logic [29:0] rpc; bit ack;
    bit e_req; logic [29:0] e_addr; logic [31:0] e_inst; logic [29:0] e_pc;
  } vec_t;

  function automatic vec_t mk(bit rst, bit en, bit rd, logic [29:0] rpc, bit ack,
                              bit e_req, logic [29:0] e_addr,
                              logic [31:0] e_inst, logic [29:0] e_pc);
    vec_t v;
    v.rst = rst; v.en = en; v.rd = rd; v.rpc = rpc; v.ack = ack;
    v.e_req = e_req; v.e_addr = e_addr; v.e_inst = e_inst; v.e_pc = e_pc;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    //          rst en rd rpc            ack req addr           inst               pc
    tbl[0]  = mk(1, 1, 0, 30'h0,          0,  0, 30'h10,        NOP,               30'h10);
    tbl[1]  = mk(1, 1, 0, 30'h0,          0,  0, 30'h10,        NOP,               30'h10);
    tbl[2]  = mk(0, 1, 0, 30'h0,          1,  1, 30'h10,        32'h8000_0010,     30'h10);
    tbl[3]  = mk(0, 1, 0, 30'h0,          1,  1, 30'h11,        32'h8000_0011,     30'h11);
    tbl[4]  = mk(0, 1, 0, 30'h0,          1,  1, 30'h12,        32'h8000_0012,     30'h12);
    tbl[5]  = mk(0, 1, 0, 30'h0,          0,  1, 30'h13,        NOP,               30'h12);
    tbl[6]  = mk(0, 1, 0, 30'h0,          0,  1, 30'h13,        NOP,               30'h12);
    tbl[7]  = mk(0, 1, 0, 30'h0,          1,  1, 30'h13,        32'h8000_0013,     30'h13);
    tbl[8]  = mk(0, 0, 0, 30'h0,          1,  1, 30'h14,        32'h8000_0013,     30'h13);
    tbl[9]  = mk(0, 0, 0, 30'h0,          0,  0, 30'h14,        32'h8000_0013,     30'h13);
    tbl[10] = mk(0, 1, 0, 30'h0,          0,  0, 30'h14,        32'h8000_0014,     30'h14);
    tbl[11] = mk(0, 1, 0, 30'h0,          1,  1, 30'h15,        32'h8000_0015,     30'h15);
    tbl[12] = mk(0, 1, 1, 30'h100,        0,  1, 30'h16,        NOP,               30'h15);
    tbl[13] = mk(0, 0, 0, 30'h0,          0,  1, 30'h16,        NOP,               30'h15);
    tbl[14] = mk(0, 1, 0, 30'h0,          1,  1, 30'h16,        NOP,               30'h15);
    tbl[15] = mk(0, 1, 0, 30'h0,          1,  1, 30'h100,       32'h8000_0100,     30'h100);
    tbl[16] = mk(0, 1, 1, 30'h3FFF_FFFF,  1,  1, 30'h101,       NOP,               30'h100);
    tbl[17] = mk(0, 1, 0, 30'h0,          1,  1, 30'h3FFF_FFFF, 32'hBFFF_FFFF,     30'h3FFF_FFFF);
    tbl[18] = mk(0, 1, 0, 30'h0,          1,  1, 30'h0,         32'h8000_0000,     30'h0);
    tbl[19] = mk(1, 1, 0, 30'h0,          0,  0, 30'h10,        NOP,               30'h10);

    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].rst, tbl[i].en, tbl[i].rd, tbl[i].rpc, int'(tbl[i].ack), 0);
      chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].e_req));
      chk($sformatf("tbl%0d_addr", i), 32'(s_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_inst", i), s_inst, tbl[i].e_inst);
      chk($sformatf("tbl%0d_pc", i), 32'(s_pc), 32'(tbl[i].e_pc));
    end

    // 2-wait-state memory: two bubbles per instruction, address held.
    mem_rand = 0; mem_waits = 2;
    cycle(1, 1, 0, 30'h0, -1, 1);
    for (int i = 0; i < 15; i++) cycle(0, 1, 0, 30'h0, -1, 1);

    // Stall on the ack at 0x20: buffer fills, then delivers exactly once.
    mem_waits = 0;
    cycle(1, 1, 0, 30'h0, -1, 1);
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 30'h20); i++)
      cycle(0, 1, 0, 30'h0, -1, 1);
    chk("reach_0x20", 32'(imem_addr), 32'h20);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 30'h0, -1, 1);
    cycle(0, 1, 0, 30'h0, -1, 1);
    chk("stall_inst", s_inst, mw(30'h20));
    chk("stall_pc", 32'(s_pc), 32'h20);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 30'h0, -1, 1);

    // Redirect to 0x100 while a 3-wait request to 0x40 is pending.
    mem_waits = 3;
    cycle(1, 1, 0, 30'h0, -1, 1);
    cycle(0, 1, 1, 30'h40, -1, 1);
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 30'h40); i++)
      cycle(0, 1, 0, 30'h0, -1, 1);
    chk("reach_0x40", 32'(imem_addr), 32'h40);
    saw_40 = 0;
    cycle(0, 1, 0, 30'h0, -1, 1);
    cycle(0, 1, 1, 30'h100, -1, 1);
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, 30'h0, -1, 1);
    chk("wrong_path_0x40", 32'(saw_40), 32'h0);

    // Two redirects in one drain, then a redirect while HELD with clk_en low.
    cycle(1, 1, 0, 30'h0, -1, 1);
    cycle(0, 1, 0, 30'h0, -1, 1);
    cycle(0, 1, 1, 30'h200, -1, 1);
    cycle(0, 1, 1, 30'h300, -1, 1);
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 30'h0, -1, 1);
    mem_waits = 0;
    cycle(0, 0, 0, 30'h0, -1, 1);
    cycle(0, 0, 1, 30'h500, -1, 1);
    chk("held_redirect_nop", s_inst, NOP);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 30'h0, -1, 1);

    // Randomized run against the reference model.
    mem_rand = 1;
    cycle(1, 1, 0, 30'h0, -1, 1);
    for (int i = 0; i < 800; i++) begin
      bit r_rst, r_en, r_rd;
      logic [29:0] r_pc;
      r_rst = ($urandom_range(99) == 0);
      r_en  = ($urandom_range(3) != 0);
      r_rd  = ($urandom_range(15) == 0);
      r_pc  = ($urandom_range(3) == 0) ? (30'h3FFF_FFFD + 30'($urandom_range(3)))
                                       : 30'($urandom);
      cycle(r_rst, r_en, r_rd, r_pc, -1, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
